// File: rtl/reset_sequencer_if.sv
// Reset sequencer bus: software request, per-domain ready/reset and status.
interface reset_sequencer_if #(
  parameter int unsigned N_DOM = 4
);
  localparam int unsigned IW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  logic             sw_rst_req;
  logic [N_DOM-1:0] dom_ready;
  logic [N_DOM-1:0] dom_rst;
  logic [IW-1:0]    cur_dom;
  logic             seq_done;
  logic             seq_err;

  // Sequencer side
  modport master (
    input  sw_rst_req,
    input  dom_ready,
    output dom_rst,
    output cur_dom,
    output seq_done,
    output seq_err
  );

  // Subsystem / controller side
  modport slave (
    output sw_rst_req,
    output dom_ready,
    input  dom_rst,
    input  cur_dom,
    input  seq_done,
    input  seq_err
  );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: holds all domain resets for HOLD_CYCLES, then releases
// domains one at a time, each after a minimum gap and its ready handshake.
// Optional ready-timeout FAULT state enabled by defining RSTSEQ_TIMEOUT_EN.
module reset_sequencer #(
  parameter int unsigned N_DOM          = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic             clk,
  input logic             rst_n,
  reset_sequencer_if.master bus
);
  localparam int unsigned IW      = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned MAX_ALL = (MAX_HG > TIMEOUT_CYCLES) ? MAX_HG : TIMEOUT_CYCLES;
  localparam int unsigned CW      = $clog2(MAX_ALL + 1);

  typedef enum logic [1:0] {
    S_ASSERT  = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2,
    S_FAULT   = 2'd3
  } state_e;

  state_e           state_q,    state_d;
  logic [CW-1:0]    cnt_q,      cnt_d;
  logic [N_DOM-1:0] dom_rst_q,  dom_rst_d;
  logic [IW-1:0]    cur_dom_q,  cur_dom_d;
  logic             seq_done_q, seq_done_d;
  logic             seq_err_q,  seq_err_d;

  logic cur_ready;
  logic gap_met;

  assign cur_ready = bus.dom_ready[cur_dom_q];
  assign gap_met   = (cnt_q >= CW'(GAP_CYCLES - 1));

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_ASSERT;
      cnt_q      <= '0;
      dom_rst_q  <= '1;
      cur_dom_q  <= '0;
      seq_done_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dom_rst_q  <= dom_rst_d;
      cur_dom_q  <= cur_dom_d;
      seq_done_q <= seq_done_d;
      seq_err_q  <= seq_err_d;
    end
  end

  // Next-state and next-output logic; software request restarts from ASSERT
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dom_rst_d  = dom_rst_q;
    cur_dom_d  = cur_dom_q;
    seq_done_d = seq_done_q;
    seq_err_d  = seq_err_q;

    if (bus.sw_rst_req) begin
      state_d    = S_ASSERT;
      cnt_d      = '0;
      dom_rst_d  = '1;
      cur_dom_d  = '0;
      seq_done_d = 1'b0;
      seq_err_d  = 1'b0;
    end else begin
      case (state_q)
        S_ASSERT: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            state_d      = S_RELEASE;
            dom_rst_d[0] = 1'b0;
            cnt_d        = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end

        S_RELEASE: begin
          // Saturating count: the gap is a minimum, ready may come much later
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
          end
          if (gap_met && cur_ready) begin
            if (cur_dom_q == IW'(N_DOM - 1)) begin
              state_d    = S_RUN;
              seq_done_d = 1'b1;
            end else begin
              cur_dom_d            = cur_dom_q + IW'(1);
              dom_rst_d[cur_dom_d] = 1'b0;
              cnt_d                = '0;
            end
          end
`ifdef RSTSEQ_TIMEOUT_EN
          // Gap is always met by the timeout point, so this branch means ready is low
          else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = S_FAULT;
            seq_err_d = 1'b1;
            for (int i = 0; i < N_DOM; i++) begin
              if (IW'(i) >= cur_dom_q) begin
                dom_rst_d[i] = 1'b1;
              end
            end
          end
`endif
        end

        S_RUN: begin
          dom_rst_d = '0;
        end

        S_FAULT: begin
          state_d = S_FAULT;
        end

        default: begin
          state_d = S_ASSERT;
        end
      endcase
    end
  end

  assign bus.dom_rst  = dom_rst_q;
  assign bus.cur_dom  = cur_dom_q;
  assign bus.seq_done = seq_done_q;
  assign bus.seq_err  = seq_err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer (N_DOM=4, HOLD=16, GAP=8, TIMEOUT=1024).
module tb_reset_sequencer;
  localparam int unsigned N_DOM = 4;
  localparam int unsigned HOLD  = 16;
  localparam int unsigned GAP   = 8;
  localparam int unsigned TMO   = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  reset_sequencer_if #(.N_DOM(N_DOM)) bus ();

  reset_sequencer #(
    .N_DOM(N_DOM), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle at which domain k is released (k==N_DOM gives seq_done rise).
  // r1 = first cycle dom_ready[1] is high (0 means always high).
  function automatic int rel_cycle(int k, int r1);
    int rel, nxt;
    rel = HOLD;
    for (int j = 0; j < k; j++) begin
      nxt = rel + GAP;
      if (j == 1 && (r1 + 1) > nxt) nxt = r1 + 1;
      rel = nxt;
    end
    return rel;
  endfunction

  // Leaves the bench in cycle 0 of a fresh sequence
  task automatic apply_reset();
    bus.sw_rst_req = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.dom_ready = 4'h0;
    apply_reset();
    checks++; if (bus.dom_rst !== 4'hF) begin failures++; $display("FAIL reset dom_rst got=%b exp=1111", bus.dom_rst); end
    checks++; if (bus.cur_dom !== 2'd0) begin failures++; $display("FAIL reset cur_dom got=%0d exp=0", bus.cur_dom); end
    checks++; if (bus.seq_done !== 1'b0) begin failures++; $display("FAIL reset seq_done got=%b exp=0", bus.seq_done); end
    checks++; if (bus.seq_err !== 1'b0) begin failures++; $display("FAIL reset seq_err got=%b exp=0", bus.seq_err); end
  endtask

  task automatic test_normal();
    bus.dom_ready = 4'hF;
    apply_reset();
    for (int c = 0; c <= 50; c++) begin
      logic [3:0] er;
      logic [1:0] ec;
      logic       ed;
      er = '0; ec = '0;
      for (int k = 0; k < N_DOM; k++) begin
        er[k] = (c < rel_cycle(k, 0));
        if (c >= rel_cycle(k, 0)) ec = 2'(k);
      end
      ed = (c >= rel_cycle(N_DOM, 0));
      checks++; if (bus.dom_rst !== er) begin failures++; $display("FAIL normal dom_rst c=%0d got=%b exp=%b", c, bus.dom_rst, er); end
      checks++; if (bus.cur_dom !== ec) begin failures++; $display("FAIL normal cur_dom c=%0d got=%0d exp=%0d", c, bus.cur_dom, ec); end
      checks++; if (bus.seq_done !== ed) begin failures++; $display("FAIL normal seq_done c=%0d got=%b exp=%b", c, bus.seq_done, ed); end
      checks++; if (bus.seq_err !== 1'b0) begin failures++; $display("FAIL normal seq_err c=%0d got=%b exp=0", c, bus.seq_err); end
      tick();
    end
  endtask

  // Continues from RUN left by test_normal
  task automatic test_sw_in_run();
    checks++; if (bus.seq_done !== 1'b1) begin failures++; $display("FAIL sw_run pre seq_done got=%b exp=1", bus.seq_done); end
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    for (int c = 0; c <= 50; c++) begin
      logic [3:0] er;
      logic       ed;
      er = '0;
      for (int k = 0; k < N_DOM; k++) er[k] = (c < rel_cycle(k, 0));
      ed = (c >= rel_cycle(N_DOM, 0));
      checks++; if (bus.dom_rst !== er) begin failures++; $display("FAIL sw_run dom_rst c=%0d got=%b exp=%b", c, bus.dom_rst, er); end
      checks++; if (bus.seq_done !== ed) begin failures++; $display("FAIL sw_run seq_done c=%0d got=%b exp=%b", c, bus.seq_done, ed); end
      tick();
    end
  endtask

  task automatic test_late_ready();
    bus.dom_ready = 4'hD;
    apply_reset();
    for (int c = 0; c <= 80; c++) begin
      logic [3:0] er;
      logic [1:0] ec;
      logic       ed;
      bus.dom_ready = (c >= 60) ? 4'hF : 4'hD;
      er = '0; ec = '0;
      for (int k = 0; k < N_DOM; k++) begin
        er[k] = (c < rel_cycle(k, 60));
        if (c >= rel_cycle(k, 60)) ec = 2'(k);
      end
      ed = (c >= rel_cycle(N_DOM, 60));
      checks++; if (bus.dom_rst !== er) begin failures++; $display("FAIL late dom_rst c=%0d got=%b exp=%b", c, bus.dom_rst, er); end
      checks++; if (bus.cur_dom !== ec) begin failures++; $display("FAIL late cur_dom c=%0d got=%0d exp=%0d", c, bus.cur_dom, ec); end
      checks++; if (bus.seq_done !== ed) begin failures++; $display("FAIL late seq_done c=%0d got=%b exp=%b", c, bus.seq_done, ed); end
      tick();
    end
  endtask

  task automatic test_rst_mid_release();
    bus.dom_ready = 4'hF;
    apply_reset();
    for (int i = 0; i < 34; i++) tick();
    checks++; if (bus.cur_dom !== 2'd2) begin failures++; $display("FAIL midrst pre cur_dom got=%0d exp=2", bus.cur_dom); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (bus.dom_rst !== 4'hF) begin failures++; $display("FAIL midrst dom_rst got=%b exp=1111", bus.dom_rst); end
    checks++; if (bus.cur_dom !== 2'd0) begin failures++; $display("FAIL midrst cur_dom got=%0d exp=0", bus.cur_dom); end
    for (int i = 0; i < 15; i++) tick();
    checks++; if (bus.dom_rst !== 4'hF) begin failures++; $display("FAIL midrst c15 dom_rst got=%b exp=1111", bus.dom_rst); end
    tick();
    checks++; if (bus.dom_rst !== 4'hE) begin failures++; $display("FAIL midrst c16 dom_rst got=%b exp=1110", bus.dom_rst); end
  endtask

  task automatic test_sw_hold_assert();
    bus.dom_ready = 4'hF;
    apply_reset();
    for (int i = 0; i < 5; i++) tick();
    bus.sw_rst_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (bus.dom_rst !== 4'hF) begin failures++; $display("FAIL swhold held%0d dom_rst got=%b exp=1111", i, bus.dom_rst); end
    end
    bus.sw_rst_req = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (bus.dom_rst !== 4'hF) begin failures++; $display("FAIL swhold c15 dom_rst got=%b exp=1111", bus.dom_rst); end
    tick();
    checks++; if (bus.dom_rst !== 4'hE) begin failures++; $display("FAIL swhold c16 dom_rst got=%b exp=1110", bus.dom_rst); end
  endtask

  // dom_ready[2] stuck low; domain 2 released at cycle 32
  task automatic test_stuck_ready();
    bus.dom_ready = 4'hB;
    apply_reset();
    for (int i = 0; i < 32 + TMO - 1; i++) tick();
    checks++; if (bus.seq_err !== 1'b0) begin failures++; $display("FAIL stuck pre seq_err got=%b exp=0", bus.seq_err); end
    checks++; if (bus.dom_rst !== 4'h8) begin failures++; $display("FAIL stuck pre dom_rst got=%b exp=1000", bus.dom_rst); end
    tick();
`ifdef RSTSEQ_TIMEOUT_EN
    checks++; if (bus.seq_err !== 1'b1) begin failures++; $display("FAIL fault seq_err got=%b exp=1", bus.seq_err); end
    checks++; if (bus.dom_rst !== 4'hC) begin failures++; $display("FAIL fault dom_rst got=%b exp=1100", bus.dom_rst); end
    checks++; if (bus.seq_done !== 1'b0) begin failures++; $display("FAIL fault seq_done got=%b exp=0", bus.seq_done); end
    for (int i = 0; i < 10; i++) tick();
    checks++; if (bus.seq_err !== 1'b1) begin failures++; $display("FAIL fault hold seq_err got=%b exp=1", bus.seq_err); end
    bus.dom_ready = 4'hF;
    bus.sw_rst_req = 1'b1;
    tick();
    bus.sw_rst_req = 1'b0;
    checks++; if (bus.seq_err !== 1'b0) begin failures++; $display("FAIL fault clr seq_err got=%b exp=0", bus.seq_err); end
    checks++; if (bus.dom_rst !== 4'hF) begin failures++; $display("FAIL fault clr dom_rst got=%b exp=1111", bus.dom_rst); end
    for (int i = 0; i < 16; i++) tick();
    checks++; if (bus.dom_rst !== 4'hE) begin failures++; $display("FAIL fault restart dom_rst got=%b exp=1110", bus.dom_rst); end
`else
    for (int i = 0; i < 20; i++) tick();
    checks++; if (bus.seq_err !== 1'b0) begin failures++; $display("FAIL stuck seq_err got=%b exp=0", bus.seq_err); end
    checks++; if (bus.dom_rst !== 4'h8) begin failures++; $display("FAIL stuck dom_rst got=%b exp=1000", bus.dom_rst); end
    checks++; if (bus.cur_dom !== 2'd2) begin failures++; $display("FAIL stuck cur_dom got=%0d exp=2", bus.cur_dom); end
    bus.dom_ready = 4'hF;
    tick();
    checks++; if (bus.dom_rst !== 4'h0) begin failures++; $display("FAIL stuck late dom_rst got=%b exp=0000", bus.dom_rst); end
`endif
  endtask

  initial begin
    bus.sw_rst_req = 1'b0;
    bus.dom_ready  = 4'h0;
    test_reset();
    test_normal();
    test_sw_in_run();
    test_late_ready();
    test_rst_mid_release();
    test_sw_hold_assert();
    test_stuck_ready();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Orders the release of N downstream reset domains after a synchronized power-on or software reset. All domain resets are held for a fixed interval, then released one domain at a time. Each release waits for a minimum gap and for that domain's ready handshake before moving on. The block sits directly behind the top-level reset synchronizer and drives the active-high reset of each subsystem.

## Interface
- N_DOM, 4: number of sequenced domains (>=1); index width IW = max(1, $clog2(N_DOM)).
- HOLD_CYCLES, 16: cycles all domains are held in reset after reset exit (>=1).
- GAP_CYCLES, 8: minimum cycles between releasing domain k and releasing domain k+1 (>=1).
- TIMEOUT_CYCLES, 1024: ready-wait limit per domain (> GAP_CYCLES); used only with the timeout feature.
- Counter width CW = $clog2(max(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)+1).

Ports:
- clk  input  1  single clock; everything is on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- sw_rst_req  input  1  software re-sequence request, level sampled each cycle.
- dom_ready  input  N_DOM  per-domain init-done; already synchronous to clk.
- dom_rst  output  N_DOM  per-domain reset, active-high, registered.
- cur_dom  output  IW  index of the domain currently being released or waited on.
- seq_done  output  1  high while all domains are released (RUN).
- seq_err  output  1  high in FAULT (ready timeout).

## Operation
- Reset (rst_n=0 at an edge) sets: state=ASSERT, cnt=0, cur_dom=0, dom_rst=all 1, seq_done=0, seq_err=0. rst_n has priority over everything.
- ASSERT:
  - cnt increments each cycle.
  - When cnt==HOLD_CYCLES-1: go to RELEASE, set dom_rst[0]<=0, cnt<=0.
- RELEASE (domain k=cur_dom):
  - dom_rst[k]=0; cnt increments and saturates at its maximum.
  - Advance condition: cnt>=GAP_CYCLES-1 AND dom_ready[k]=1.
  - On advance with k<N_DOM-1: cur_dom<=k+1, dom_rst[k+1]<=0, cnt<=0.
  - On advance with k==N_DOM-1: go to RUN, seq_done<=1.
- RUN:
  - Steady state. dom_ready is ignored and dom_rst stays all 0.
  - cur_dom holds N_DOM-1.
- FAULT (timeout build only):
  - seq_err=1. dom_rst[k]<=1 is re-asserted, and domains above k stay 1.
  - Domains below k stay released.
  - The block stays in FAULT until sw_rst_req or rst_n.
- sw_rst_req=1 in any state, with rst_n=1:
  - Next state is ASSERT with dom_rst=all 1, cnt=0, cur_dom=0, seq_done=0, seq_err=0.
  - Held high, it keeps restarting the hold count. The hold starts counting on the first cycle after it drops.
- dom_ready of domains other than cur_dom has no effect.
- Ready asserted before GAP elapses is accepted once the gap expires; the gap is a minimum, not a window.
- Ready deasserting before the gap expires means the block keeps waiting.

## Timing
- Cycle 0 is the first cycle with rst_n=1 and sw_rst_req=0 after entering ASSERT.
- dom_rst[0] falls at cycle HOLD_CYCLES.
- With dom_ready constant 1, dom_rst[k] falls at cycle HOLD_CYCLES + k·GAP_CYCLES.
- seq_done rises at cycle HOLD_CYCLES + N_DOM·GAP_CYCLES.
- If ready for domain k arrives late (first sampled high at cycle t, with t past the gap), domain k+1 is released, or seq_done is set, at cycle t+1.
- All outputs are registered; there is no combinational path from input to output.
- sw_rst_req: dom_rst goes all-1 one cycle after the cycle in which it is sampled high.

## Configuration
- RSTSEQ_TIMEOUT_EN defined:
  - In RELEASE, if cnt==TIMEOUT_CYCLES-1 and dom_ready[k]=0, go to FAULT at the next edge.
  - Ready sampled high in that same cycle wins; no fault is raised.
- RSTSEQ_TIMEOUT_EN undefined:
  - No FAULT state; RELEASE waits for ready indefinitely.
  - seq_err is tied 0.

## Test plan
- N_DOM=4, HOLD=16, GAP=8, dom_ready=4'hF: dom_rst falls at cycles 16, 24, 32, 40 for domains 0..3; seq_done rises at cycle 48; seq_err stays 0.
- dom_ready[1] is held 0 until cycle 60, then driven to 1: dom_rst[2] falls at cycle 61; cur_dom stays 1 during cycles 24–60.
- RSTSEQ_TIMEOUT_EN, TIMEOUT=1024, dom_ready[2] stuck at 0:
  - FAULT entered 1024 cycles after dom_rst[2] fell.
  - seq_err=1, dom_rst=4'b1100, seq_done=0.
  - A later sw_rst_req pulse clears seq_err and restarts the sequence from ASSERT.
- sw_rst_req pulsed for 1 cycle while in RUN: next cycle dom_rst=4'hF and seq_done=0; the full release pattern repeats with the same timing, offset from the pulse.
- rst_n driven low for 1 cycle mid-RELEASE (cur_dom=2): next cycle dom_rst=4'hF, cur_dom=0, cnt restarts from 0.
- sw_rst_req held high for 5 cycles during ASSERT: dom_rst[0] falls HOLD_CYCLES cycles after sw_rst_req deasserts.
